// File: rtl/fetch_stage_ctrl_pkg.sv
// Shared constants and types for the fetch stage: opcodes, FSM states,
// default bubble instruction.
package fetch_stage_ctrl_pkg;

  localparam logic [3:0] OP_B   = 4'hC;
  localparam logic [3:0] OP_BR  = 4'hD;
  localparam logic [3:0] OP_PCS = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [15:0] NOP_INST_DEFAULT = 16'h0000;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_HLT_WAIT = 2'd1,
    ST_HALTED   = 2'd2
  } fetch_state_t;

  // True when the instruction word is a halt.
  function automatic logic is_hlt(input logic [15:0] inst);
    return inst[15:12] == OP_HLT;
  endfunction

endpackage

// File: rtl/addsub_16bit.sv
// 16-bit adder/subtractor: sum = a + b (sub=0) or a - b (sub=1),
// signed overflow flag.
module addsub_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        sub,
  output logic [15:0] sum,
  output logic        ovfl
);

  logic [15:0] b_eff;

  // Two's-complement subtract by inverting b and injecting a carry.
  always_comb begin
    b_eff = sub ? ~b : b;
    sum   = a + b_eff + {15'd0, sub};
    ovfl  = (a[15] == b_eff[15]) && (sum[15] != a[15]);
  end

endmodule

// File: rtl/fetch_stage_ctrl_ifid_pipe_reg.sv
// IF/ID pipeline register: {inst, pc_plus2, valid}, with load enable and
// synchronous flush to a bubble. Reset and flush both produce a bubble.
module ifid_pipe_reg #(
  parameter logic [15:0] NOP_INST = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        flush,
  input  logic [15:0] d_inst,
  input  logic [15:0] d_pc_plus2,
  input  logic        d_valid,
  output logic [15:0] q_inst,
  output logic [15:0] q_pc_plus2,
  output logic        q_valid
);

  logic [32:0] q;

  // Priority: reset, then flush, then enabled load; otherwise hold.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= {NOP_INST, 16'h0000, 1'b0};
    end else if (flush) begin
      q <= {NOP_INST, 16'h0000, 1'b0};
    end else if (en) begin
      q <= {d_inst, d_pc_plus2, d_valid};
    end
  end

  assign q_inst     = q[32:17];
  assign q_pc_plus2 = q[16:1];
  assign q_valid    = q[0];

endmodule

// File: rtl/fetch_stage_ctrl.sv
// Fetch stage: owns the PC, drives the instruction address, fills IF/ID,
// flushes on redirect and sequences HLT (wait for commit, then halt).
// Handshake: there is no backpressure from imem; stall holds PC and IF/ID,
// redirect_valid is a single-cycle command that always wins over stall.
module fetch_stage_ctrl
  import fetch_stage_ctrl_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP_INST = NOP_INST_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  input  logic        hlt_commit,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  output logic [15:0] ifid_inst,
  output logic [15:0] ifid_pc_plus2,
  output logic        ifid_valid,
  output logic        halted,
  output logic [1:0]  fsm_state
);

  fetch_state_t state;
  logic [15:0]  pc;
  logic [15:0]  pc_plus2;
  logic         hlt_fetch;
  logic         ifid_en;
  logic         ifid_flush;

  addsub_16bit u_pc_inc (
    .a    (pc),
    .b    (16'h0002),
    .sub  (1'b0),
    .sum  (pc_plus2),
    .ovfl ()
  );

  assign hlt_fetch = is_hlt(imem_data);
  assign imem_addr = pc;
  assign fsm_state = state;

  // IF/ID control: flush on commit/redirect or while waiting on HLT,
  // load only in RUN without stall, freeze entirely once halted.
  always_comb begin
    ifid_en    = 1'b0;
    ifid_flush = 1'b0;
    if (state != ST_HALTED) begin
      if (hlt_commit || redirect_valid) begin
        ifid_flush = 1'b1;
      end else if (!stall) begin
        if (state == ST_HLT_WAIT) ifid_flush = 1'b1;
        else                      ifid_en    = 1'b1;
      end
    end
  end

  // PC / halt FSM with registered halted flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_RUN;
      pc     <= RESET_PC & 16'hFFFE;
      halted <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (hlt_commit) begin
            state  <= ST_HALTED;
            halted <= 1'b1;
          end else if (redirect_valid) begin
            pc <= redirect_pc & 16'hFFFE;
          end else if (!stall) begin
            if (hlt_fetch) state <= ST_HLT_WAIT;
            else           pc    <= pc_plus2;
          end
        end
        ST_HLT_WAIT: begin
          if (hlt_commit) begin
            state  <= ST_HALTED;
            halted <= 1'b1;
          end else if (redirect_valid) begin
            pc    <= redirect_pc & 16'hFFFE;
            state <= ST_RUN;
          end
        end
        ST_HALTED: begin
          halted <= 1'b1;
        end
        default: begin
          state <= ST_RUN;
        end
      endcase
    end
  end

  ifid_pipe_reg #(.NOP_INST(NOP_INST)) u_ifid (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (ifid_en),
    .flush      (ifid_flush),
    .d_inst     (imem_data),
    .d_pc_plus2 (pc_plus2),
    .d_valid    (1'b1),
    .q_inst     (ifid_inst),
    .q_pc_plus2 (ifid_pc_plus2),
    .q_valid    (ifid_valid)
  );

endmodule

// File: tb/tb_fetch_stage_ctrl.sv
// Bench for fetch_stage_ctrl: behavioural fetch model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_fetch_stage_ctrl;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        hlt_commit;
  logic [15:0] imem_addr;
  logic [15:0] imem_data;
  logic [15:0] ifid_inst;
  logic [15:0] ifid_pc_plus2;
  logic        ifid_valid;
  logic        halted;
  logic [1:0]  fsm_state;

  int total;
  int bad;

  // Address at which instruction memory holds an HLT (odd = none).
  logic [15:0] hlt_addr;

  // Model state.
  logic        model_live;
  logic [15:0] m_pc;
  logic [15:0] m_inst;
  logic [15:0] m_pp2;
  logic        m_valid;
  logic        m_halted;
  logic        m_waiting;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  fetch_stage_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .hlt_commit     (hlt_commit),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .ifid_inst      (ifid_inst),
    .ifid_pc_plus2  (ifid_pc_plus2),
    .ifid_valid     (ifid_valid),
    .halted         (halted),
    .fsm_state      (fsm_state)
  );

  // Memory contents: ADD-class word tagged with its address, or HLT.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (a == hlt_addr) return 16'hF000;
    return {4'h1, a[11:0]};
  endfunction

  always_comb imem_data = mem_word(imem_addr);

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  always @(posedge clk) begin
    logic [15:0] w;
    if (!rst_n) begin
      model_live = 1'b1;
      m_pc = 16'h0000; m_inst = 16'h0000; m_pp2 = 16'h0000;
      m_valid = 1'b0; m_halted = 1'b0; m_waiting = 1'b0;
    end else if (model_live && !m_halted) begin
      if (hlt_commit) begin
        m_halted = 1'b1; m_inst = 16'h0000; m_valid = 1'b0;
      end else if (redirect_valid) begin
        m_pc = redirect_pc & 16'hFFFE;
        m_inst = 16'h0000; m_valid = 1'b0; m_waiting = 1'b0;
      end else if (!stall) begin
        if (m_waiting) begin
          m_inst = 16'h0000; m_valid = 1'b0;
        end else begin
          w = mem_word(m_pc);
          m_inst = w; m_pp2 = m_pc + 16'h0002; m_valid = 1'b1;
          if (w[15:12] == 4'hF) m_waiting = 1'b1;
          else                  m_pc = m_pc + 16'h0002;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (model_live) begin
      check("cyc_imem_addr", imem_addr, m_pc);
      check("cyc_ifid_valid", {15'd0, ifid_valid}, {15'd0, m_valid});
      check("cyc_ifid_inst", ifid_inst, m_inst);
      if (m_valid) check("cyc_ifid_pc_plus2", ifid_pc_plus2, m_pp2);
      check("cyc_halted", {15'd0, halted}, {15'd0, m_halted});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic redirect_to(input logic [15:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    step();
    redirect_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    total = 0; bad = 0;
    model_live = 1'b0;
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 16'h0000; hlt_commit = 1'b0; hlt_addr = 16'hFFFF;
    @(negedge clk);
    step();
    rst_n = 1'b1;

    // Reset state
    check("rst_addr", imem_addr, 16'h0000);
    check("rst_valid", {15'd0, ifid_valid}, 16'h0000);
    check("rst_inst", ifid_inst, 16'h0000);
    check("rst_halted", {15'd0, halted}, 16'h0000);

    // 1: sequential fetch
    step();
    check("seq_addr_2", imem_addr, 16'h0002);
    check("seq_pp2_2", ifid_pc_plus2, 16'h0002);
    check("seq_valid", {15'd0, ifid_valid}, 16'h0001);
    check("seq_inst_0", ifid_inst, 16'h1000);
    step();
    check("seq_addr_4", imem_addr, 16'h0004);
    check("seq_pp2_4", ifid_pc_plus2, 16'h0004);
    step();
    check("seq_addr_6", imem_addr, 16'h0006);
    check("seq_pp2_6", ifid_pc_plus2, 16'h0006);

    // 2: redirect with odd target
    redirect_to(16'h0010);
    check("redir_addr_10", imem_addr, 16'h0010);
    redirect_to(16'h0041);
    check("redir_addr_40", imem_addr, 16'h0040);
    check("redir_valid", {15'd0, ifid_valid}, 16'h0000);
    check("redir_inst_nop", ifid_inst, 16'h0000);
    step();
    check("redir_resume_addr", imem_addr, 16'h0042);
    check("redir_resume_inst", ifid_inst, 16'h1040);
    check("redir_resume_pp2", ifid_pc_plus2, 16'h0042);

    // 3: redirect beats stall, then stall holds
    stall = 1'b1;
    redirect_to(16'h0080);
    check("stallredir_addr", imem_addr, 16'h0080);
    check("stallredir_valid", {15'd0, ifid_valid}, 16'h0000);
    stall = 1'b0;
    step();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_addr", imem_addr, 16'h0082);
      check("stall_inst", ifid_inst, 16'h1080);
    end
    stall = 1'b0;

    // 4: HLT then commit
    hlt_addr = 16'h0020;
    redirect_to(16'h0020);
    step();
    check("hlt_inst", ifid_inst, 16'hF000);
    check("hlt_pc_hold", imem_addr, 16'h0020);
    step();
    check("hlt_bubble", {15'd0, ifid_valid}, 16'h0000);
    check("hlt_pc_hold2", imem_addr, 16'h0020);
    hlt_commit = 1'b1;
    step();
    hlt_commit = 1'b0;
    check("halted_set", {15'd0, halted}, 16'h0001);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) redirect_valid = 1'b1;
      redirect_pc = 16'h0300;
      step();
      redirect_valid = 1'b0;
      check("halted_stay", {15'd0, halted}, 16'h0001);
      check("halted_pc", imem_addr, 16'h0020);
    end

    // 5: HLT on wrong path, redirect out of HLT_WAIT
    do_reset();
    redirect_to(16'h0020);
    step();
    check("hw_inst", ifid_inst, 16'hF000);
    redirect_to(16'h0100);
    check("hw_redir_addr", imem_addr, 16'h0100);
    check("hw_halted", {15'd0, halted}, 16'h0000);
    step();
    check("hw_run_addr", imem_addr, 16'h0102);
    check("hw_run_valid", {15'd0, ifid_valid}, 16'h0001);

    // 6: PC wrap, then reset in HLT_WAIT
    hlt_addr = 16'hFFFF;
    redirect_to(16'hFFFE);
    step();
    check("wrap_addr", imem_addr, 16'h0000);
    check("wrap_pp2", ifid_pc_plus2, 16'h0000);
    check("wrap_inst", ifid_inst, 16'h1FFE);
    hlt_addr = 16'h0030;
    redirect_to(16'h0030);
    step();
    check("rstwait_hlt", ifid_inst, 16'hF000);
    do_reset();
    check("rstwait_addr", imem_addr, 16'h0000);
    check("rstwait_valid", {15'd0, ifid_valid}, 16'h0000);
    check("rstwait_halted", {15'd0, halted}, 16'h0000);
    step();
    check("rstwait_run", imem_addr, 16'h0002);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
